// File: rtl/encoder_pkg.sv
// +--------------------------------------------------------------------------+
// | encoder_pkg : shared types and widths for the serial 4-to-2 encoder       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package encoder_pkg;

  localparam int IN_W  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/prio_enc_4.sv
// +--------------------------------------------------------------------------+
// | prio_enc_4 : combinational 4-bit priority encoder, direction selectable  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module prio_enc_4
  import encoder_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Scan so that the preferred end is written last and therefore wins.
  always_comb begin
    idx  = '0;
    zero = (vec == '0);
    if (LOW_FIRST) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/encoder_4_to_2_serial.sv
// +--------------------------------------------------------------------------+
// | encoder_4_to_2_serial : serialises a multi-hot word into index beats     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module encoder_4_to_2_serial
  import encoder_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] Q,
  output logic             last,
  output logic             none
);

  state_t            r_state, w_state_nx;
  logic [IN_W-1:0]   r_pending, w_pending_nx;
  logic              r_none, w_none_nx;
  logic [IDX_W-1:0]  w_idx;
  logic              w_zero;
  logic              w_last;

  prio_enc_4 #(
    .LOW_FIRST (LOW_FIRST)
  ) u_prio (
    .vec  (r_pending),
    .idx  (w_idx),
    .zero (w_zero)
  );

  assign w_last = w_zero | $onehot(r_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_none    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      r_none    <= w_none_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_pending_nx = r_pending;
    w_none_nx    = r_none;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_pending_nx = D;
          w_none_nx    = (D == '0);
          w_state_nx   = SERVE;
        end
      end
      SERVE: begin
        if (out_ready) begin
          // Clearing bit 0 of an all-zero word is harmless, so D==0 needs no special case.
          w_pending_nx = r_pending & ~(IN_W'(1) << w_idx);
          if (w_last) begin
            w_none_nx  = 1'b0;
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it stays low for the whole reset pulse.
  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == SERVE);
  assign Q         = out_valid ? w_idx : '0;
  assign last      = out_valid && w_last;
  assign none      = r_none;

endmodule

`default_nettype wire

// File: tb/tb_encoder_4_to_2_serial.sv
// +--------------------------------------------------------------------------+
// | tb_encoder_4_to_2_serial : directed vectors for both service orders      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_encoder_4_to_2_serial;

  typedef struct {
    logic [3:0] d;
    int         beats;
    logic [7:0] q_lo;   // beat k index at [2k+:2], lowest-first order
    logic [7:0] q_hi;   // beat k index at [2k+:2], highest-first order
    logic       none;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] D = 4'b0000;
  logic       out_ready = 1'b0;

  logic       in_ready_lo, out_valid_lo, last_lo, none_lo;
  logic [1:0] q_lo;
  logic       in_ready_hi, out_valid_hi, last_hi, none_hi;
  logic [1:0] q_hi;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[6];

  always #5 clk = ~clk;

  encoder_4_to_2_serial #(.LOW_FIRST(1'b1)) dut_lo (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_lo),
    .D (D), .out_valid (out_valid_lo), .out_ready (out_ready),
    .Q (q_lo), .last (last_lo), .none (none_lo)
  );

  encoder_4_to_2_serial #(.LOW_FIRST(1'b0)) dut_hi (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready_hi),
    .D (D), .out_valid (out_valid_hi), .out_ready (out_ready),
    .Q (q_hi), .last (last_hi), .none (none_hi)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] elo, input logic [1:0] ehi,
                          input logic elast, input logic enone);
    chk({tag, " out_valid_lo"}, {7'd0, out_valid_lo}, 8'd1);
    chk({tag, " out_valid_hi"}, {7'd0, out_valid_hi}, 8'd1);
    chk({tag, " in_ready_lo"},  {7'd0, in_ready_lo},  8'd0);
    chk({tag, " q_lo"},         {6'd0, q_lo},         {6'd0, elo});
    chk({tag, " q_hi"},         {6'd0, q_hi},         {6'd0, ehi});
    chk({tag, " last_lo"},      {7'd0, last_lo},      {7'd0, elast});
    chk({tag, " last_hi"},      {7'd0, last_hi},      {7'd0, elast});
    chk({tag, " none_lo"},      {7'd0, none_lo},      {7'd0, enone});
    chk({tag, " none_hi"},      {7'd0, none_hi},      {7'd0, enone});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " out_valid_lo"}, {7'd0, out_valid_lo}, 8'd0);
    chk({tag, " out_valid_hi"}, {7'd0, out_valid_hi}, 8'd0);
    chk({tag, " in_ready_lo"},  {7'd0, in_ready_lo},  8'd1);
    chk({tag, " in_ready_hi"},  {7'd0, in_ready_hi},  8'd1);
  endtask

  // Accept one word and drain it with out_ready held high; called 1 time unit after an edge.
  task automatic run_word(input vec_t v, input int id);
    string tag;
    tag = $sformatf("vec%0d", id);
    chk_idle({tag, " pre"});
    in_valid  = 1'b1;
    D         = v.d;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    D        = 4'b0000;
    for (int k = 0; k < v.beats; k++) begin
      chk_beat($sformatf("%s beat%0d", tag, k), v.q_lo[2*k +: 2], v.q_hi[2*k +: 2],
               (k == v.beats - 1), v.none);
      @(posedge clk); #1;
    end
    chk_idle({tag, " post"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0100, 1, 8'h02, 8'h02, 1'b0};
    tbl[1] = '{4'b1011, 3, 8'h34, 8'h07, 1'b0};
    tbl[2] = '{4'b0000, 1, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{4'b1111, 4, 8'hE4, 8'h1B, 1'b0};
    tbl[4] = '{4'b0110, 2, 8'h09, 8'h06, 1'b0};
    tbl[5] = '{4'b1000, 1, 8'h03, 8'h03, 1'b0};

    // Reset state while rst_n is held low.
    #3;
    chk("rst in_ready_lo",  {7'd0, in_ready_lo},  8'd0);
    chk("rst in_ready_hi",  {7'd0, in_ready_hi},  8'd0);
    chk("rst out_valid_lo", {7'd0, out_valid_lo}, 8'd0);
    chk("rst q_lo",         {6'd0, q_lo},         8'd0);
    chk("rst last_lo",      {7'd0, last_lo},      8'd0);
    chk("rst none_lo",      {7'd0, none_lo},      8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after rst");

    for (int i = 0; i < 6; i++) run_word(tbl[i], i);

    // Back-pressure: 3 stalled cycles per beat, a stray word offered during SERVE.
    in_valid  = 1'b1;
    D         = 4'b1111;
    out_ready = 1'b0;
    @(posedge clk); #1;
    D = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        chk_beat($sformatf("stall b%0d s%0d", k, s), tbl[3].q_lo[2*k +: 2],
                 tbl[3].q_hi[2*k +: 2], (k == 3), 1'b0);
        @(posedge clk); #1;
      end
      chk_beat($sformatf("stall b%0d go", k), tbl[3].q_lo[2*k +: 2],
               tbl[3].q_hi[2*k +: 2], (k == 3), 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk_idle("stall post");
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall no extra lo", {7'd0, out_valid_lo}, 8'd0);

    // Asynchronous reset in the middle of a word.
    in_valid  = 1'b1;
    D         = 4'b1111;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_beat("pre-rst beat2", 2'd2, 2'd1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid_lo", {7'd0, out_valid_lo}, 8'd0);
    chk("midrst out_valid_hi", {7'd0, out_valid_hi}, 8'd0);
    chk("midrst in_ready_lo",  {7'd0, in_ready_lo},  8'd0);
    chk("midrst q_lo",         {6'd0, q_lo},         8'd0);
    chk("midrst last_lo",      {7'd0, last_lo},      8'd0);
    chk("midrst pending_lo",   {4'd0, dut_lo.r_pending}, 8'd0);
    chk("midrst pending_hi",   {4'd0, dut_hi.r_pending}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("postrst c%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
